fetch_prefetch_queue: RTL and testbench

//   Instruction prefetch queue between the unified inst/data memory port and the IF/ID register.
//   - Fetches sequential instructions into a small FIFO on cycles when the MEM stage is not using the single memory port.
//   - Hands {PC, PC+4, instruction} to decode, which hides structural stalls behind buffered instructions.
//   - Flushes and restarts on a branch/jump redirect from the MEM stage.

---
 rtl/fetch_prefetch_queue_if.sv | 31 +++
 rtl/fetch_prefetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Handshake bundle between the prefetch queue, the shared memory port, the
// MEM-stage redirect source and the decode stage.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          mem_busy;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc4;
  logic [31:0]   out_inst;
  logic [LW-1:0] level;
  logic [31:0]   port_lost;

  modport master (
    input  mem_busy, mem_rdata, redirect, redirect_pc, id_ready,
    output mem_req, mem_addr, out_valid, out_pc, out_pc4, out_inst, level, port_lost
  );

  modport slave (
    output mem_busy, mem_rdata, redirect, redirect_pc, id_ready,
    input  mem_req, mem_addr, out_valid, out_pc, out_pc4, out_inst, level, port_lost
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetch FIFO that fetches on idle cycles of the
// shared memory port and presents {pc, pc+4, inst} to decode.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.master bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   port_lost_q, port_lost_d;

  // Each entry packs {pc, instruction}; storage is data-only and never reset.
  logic [63:0]   entry_q [DEPTH];
  logic [63:0]   entry_d;
  logic [63:0]   head;

  logic          mem_req;
  logic          grant;
  logic          pop;
  logic          empty;

  always_comb begin
    empty       = (count_q == '0);
    mem_req     = ~rst & ~bus.redirect & (count_q < FULL);
    grant       = mem_req & ~bus.mem_busy;
    pop         = ~empty & bus.id_ready & ~bus.redirect;
    entry_d     = {fetch_pc_q, bus.mem_rdata};

    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_pc_d  = fetch_pc_q;
    port_lost_d = (mem_req & bus.mem_busy) ? sat_inc32(port_lost_q) : port_lost_q;

    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (grant) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({grant, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fetch_pc_q  <= RESET_PC;
      port_lost_q <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fetch_pc_q  <= fetch_pc_d;
      port_lost_q <= port_lost_d;
    end
  end

  // grant is already low under rst and redirect, so no extra qualification here.
  always_ff @(posedge clk) begin
    if (grant) begin
      entry_q[wr_ptr_q] <= entry_d;
    end
  end

  // Outputs come only from registered state; mem_rdata is never bypassed.
  always_comb begin
    head          = entry_q[rd_ptr_q];
    bus.mem_req   = mem_req;
    bus.mem_addr  = fetch_pc_q;
    bus.out_valid = ~empty;
    bus.out_pc    = empty ? 32'd0 : head[63:32];
    bus.out_pc4   = empty ? 32'd0 : head[63:32] + 32'd4;
    bus.out_inst  = empty ? NOP   : head[31:0];
    bus.level     = count_q;
    bus.port_lost = port_lost_q;
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .NOP     (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0000_00A0 + addr;
  endfunction

  // Memory answers combinationally for whatever address the queue presents.
  always_comb bus.mem_rdata = mem_word(bus.mem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_lost;
  bit          known;
  int          n_vec;
  int          n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare outputs, then advance the model.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit busy, input bit idr);
    bit          m_req;
    logic [31:0] e_pc, e_pc4, e_inst;
    @(negedge clk);
    rst             = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.mem_busy    = busy;
    bus.id_ready    = idr;
    #1;
    m_req = !r && !rd && (mq.size() < DEPTH);
    check_eq("mem_req", {31'd0, bus.mem_req}, {31'd0, m_req});
    if (known) begin
      if (mq.size() == 0) begin
        e_pc = 32'd0; e_pc4 = 32'd0; e_inst = NOP;
      end else begin
        e_pc = mq[0].pc; e_pc4 = mq[0].pc + 32'd4; e_inst = mq[0].inst;
      end
      check_eq("mem_addr",  bus.mem_addr, m_fetch);
      check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      check_eq("out_pc",    bus.out_pc, e_pc);
      check_eq("out_pc4",   bus.out_pc4, e_pc4);
      check_eq("out_inst",  bus.out_inst, e_inst);
      check_eq("level",     32'(bus.level), 32'(mq.size()));
      check_eq("port_lost", bus.port_lost, m_lost);
    end
    if (r) begin
      mq.delete();
      m_fetch = RESET_PC;
      m_lost  = 32'd0;
      known   = 1'b1;
    end else begin
      if (m_req && busy && m_lost != 32'hFFFF_FFFF) m_lost++;
      if (rd) begin
        mq.delete();
        m_fetch = {rpc[31:2], 2'b00};
      end else begin
        if (mq.size() != 0 && idr) void'(mq.pop_front());
        if (m_req && !busy) begin
          mq.push_back('{pc: m_fetch, inst: mem_word(m_fetch)});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.mem_busy    = 1'b0;
    bus.id_ready    = 1'b0;
    known           = 1'b0;
    n_vec           = 0;
    n_bad           = 0;
    m_fetch         = RESET_PC;
    m_lost          = 32'd0;

    // Reset, then fill with decode stalled; extra cycles confirm mem_req drops when full.
    step(1, 0, 32'd0, 0, 0);
    repeat (6) step(0, 0, 32'd0, 0, 0);
    // Drain while refilling.
    repeat (4) step(0, 0, 32'd0, 0, 1);
    // Port stolen by MEM: queue drains to empty, port_lost accumulates.
    repeat (6) step(0, 0, 32'd0, 1, 1);
    // Build level 3 from empty, then redirect to an unaligned target.
    repeat (3) step(0, 0, 32'd0, 0, 0);
    step(0, 1, 32'h0000_0102, 0, 1);
    repeat (3) step(0, 0, 32'd0, 0, 0);
    // Level 2 with simultaneous grant and pop, across several pointer wraps.
    step(0, 1, 32'h0000_0200, 0, 0);
    repeat (2) step(0, 0, 32'd0, 0, 0);
    repeat (12) step(0, 0, 32'd0, 0, 1);
    // Reset collides with a redirect at level 3.
    step(0, 1, 32'h0000_0300, 0, 0);
    repeat (3) step(0, 0, 32'd0, 0, 0);
    step(1, 1, 32'h0000_0444, 0, 1);
    repeat (3) step(0, 0, 32'd0, 0, 1);
    // Redirect held several cycles: last target wins.
    step(0, 1, 32'h0000_0500, 0, 1);
    step(0, 1, 32'h0000_0604, 1, 1);
    step(0, 1, 32'h0000_0708, 0, 0);
    repeat (4) step(0, 0, 32'd0, 0, 0);
    // Fetch address wrapping past 2^32.
    step(0, 1, 32'hFFFF_FFF4, 0, 0);
    repeat (6) step(0, 0, 32'd0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      bit          r, rd, busy, idr;
      logic [31:0] rpc;
      r    = ($urandom_range(199) == 0);
      rd   = ($urandom_range(19) == 0);
      busy = ($urandom_range(2) == 0);
      idr  = ($urandom_range(1) == 0);
      rpc  = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
      step(r, rd, rpc, busy, idr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
